// File: rtl/imm_operand_stage_pkg.sv
// Shared CPU24 immediate-stage constants: format codes, sign positions and FSM states.
// Bit numbers are MSB-first (bit 0 is the MSB of a 24-bit word).
package imm_operand_stage_pkg;

    localparam logic [1:0] FMT_IMM8  = 2'd0;
    localparam logic [1:0] FMT_IMM12 = 2'd1;
    localparam logic [1:0] FMT_IMM18 = 2'd2;
    localparam logic [1:0] FMT_LONG  = 2'd3;

    localparam logic [4:0] SX_POS_IMM8  = 5'd16;
    localparam logic [4:0] SX_POS_IMM12 = 5'd12;
    localparam logic [4:0] SX_POS_IMM18 = 5'd6;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_LONG_LO = 1'b1
    } state_e;

    function automatic logic [4:0] sx_pos(input logic [1:0] fmt);
        case (fmt)
            FMT_IMM8:  sx_pos = SX_POS_IMM8;
            FMT_IMM18: sx_pos = SX_POS_IMM18;
            // LONG never uses the extended value; IMM12 position keeps the mux small
            default:   sx_pos = SX_POS_IMM12;
        endcase
    endfunction

endpackage

// File: rtl/imm_operand_stage_sext.sv
// SignExtend_24bit: copies bit pos into bits 0..pos-1 (MSB-first numbering).
module SignExtend_24bit (
    input  logic [0:23] a,
    input  logic [4:0]  pos,
    output logic [0:23] y
);

    always_comb begin
        y = a;
        for (int i = 0; i < 24; i++) begin
            if (i < int'(pos)) begin
                y[i] = a[pos];
            end
        end
    end

endmodule

// File: rtl/imm_operand_stage.sv
// Decode-side immediate operand stage: selects and sign-extends the immediate field,
// assembles two-beat long immediates and registers the operand with valid/ready.
module imm_operand_stage
    import imm_operand_stage_pkg::*;
#(
    parameter logic [0:23] IMM_RESET = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:23] in_instr,
    input  logic [0:1]  in_fmt,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:23] out_imm,
    output logic        out_long
);

    state_e      state;
    logic [0:11] hi_reg;
    logic [4:0]  sx_sel;
    logic [0:23] sx_a;
    logic [0:23] sx_y;
    logic        accept;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Bits above the field are zeroed before extension so only the field reaches the extender
    always_comb begin
        sx_sel = sx_pos(in_fmt);
        sx_a   = in_instr;
        for (int i = 0; i < 24; i++) begin
            if (i < int'(sx_sel)) begin
                sx_a[i] = 1'b0;
            end
        end
    end

    SignExtend_24bit u_sext (
        .a   (sx_a),
        .pos (sx_sel),
        .y   (sx_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            hi_reg    <= '0;
            out_valid <= 1'b0;
            out_long  <= 1'b0;
            out_imm   <= IMM_RESET;
        end else if (flush) begin
            state     <= ST_IDLE;
            hi_reg    <= '0;
            out_valid <= 1'b0;
            out_long  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (in_fmt == FMT_LONG) begin
                            hi_reg <= in_instr[12:23];
                            state  <= ST_LONG_LO;
                        end else begin
                            out_imm   <= sx_y;
                            out_valid <= 1'b1;
                            out_long  <= 1'b0;
                        end
                    end
                    ST_LONG_LO: begin
                        out_imm   <= {hi_reg, in_instr[12:23]};
                        out_valid <= 1'b1;
                        out_long  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imm_operand_stage.sv
// Scoreboard bench for imm_operand_stage: a transaction-level model pushes expected
// operands; a negedge monitor checks handshakes, ready and held values.
module tb_imm_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_instr = '0;
    logic [1:0]  in_fmt = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_imm;
    logic        out_long;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [23:0] imm;
        logic        lng;
    } exp_t;
    exp_t exp_q[$];

    // Model state
    bit          m_valid = 1'b0;
    bit          m_pend = 1'b0;
    logic [11:0] m_hi = '0;

    always #5 clk = ~clk;

    imm_operand_stage #(.IMM_RESET(24'h000000)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_fmt    (in_fmt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_long  (out_long)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [23:0] ext(input logic [23:0] w, input logic [1:0] f);
        case (f)
            2'd0:    ext = 24'($signed(w[7:0]));
            2'd1:    ext = 24'($signed(w[11:0]));
            default: ext = 24'($signed(w[17:0]));
        endcase
    endfunction

    // Reference model: evaluates the pre-edge inputs at every rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_hi    = '0;
            exp_q.delete();
        end else if (flush) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_hi    = '0;
            exp_q.delete();
        end else begin
            bit acc;
            acc = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (acc) begin
                if (m_pend) begin
                    exp_q.push_back('{imm: {m_hi, in_instr[11:0]}, lng: 1'b1});
                    m_valid = 1'b1;
                    m_pend  = 1'b0;
                end else if (in_fmt == 2'd3) begin
                    m_hi   = in_instr[11:0];
                    m_pend = 1'b1;
                end else begin
                    exp_q.push_back('{imm: ext(in_instr, in_fmt), lng: 1'b0});
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            bit have;
            have = exp_q.size() > 0;
            chk("out_valid", 32'(out_valid), 32'(have));
            chk("in_ready", 32'(in_ready), 32'(!flush && (!have || out_ready)));
            if (out_valid && have) begin
                chk("out_imm", 32'(out_imm), 32'(exp_q[0].imm));
                chk("out_long", 32'(out_long), 32'(exp_q[0].lng));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit v, input logic [23:0] w, input logic [1:0] f,
                        input bit rdy, input bit fl);
        in_valid  = v;
        in_instr  = w;
        in_fmt    = f;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset imm", 32'(out_imm), 32'h000000);
        chk("reset long", 32'(out_long), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Sign extension and field selection, back to back
        step(1, 24'h0000FF, 2'd0, 1, 0);
        chk("imm8 valid", 32'(out_valid), 32'd1);
        chk("imm8 value", 32'(out_imm), 32'hFFFFFF);
        step(1, 24'hABC7FF, 2'd1, 1, 0);
        chk("imm12 value", 32'(out_imm), 32'h0007FF);
        step(1, 24'h020000, 2'd2, 1, 0);
        chk("imm18 valid", 32'(out_valid), 32'd1);
        chk("imm18 value", 32'(out_imm), 32'hFE0000);

        // Long immediate
        step(1, 24'h000123, 2'd3, 1, 0);
        chk("long beat1 valid", 32'(out_valid), 32'd0);
        step(1, 24'h000456, 2'd0, 1, 0);
        chk("long value", 32'(out_imm), 32'h123456);
        chk("long flag", 32'(out_long), 32'd1);

        // Back-pressure
        step(0, 24'h0, 2'd0, 1, 0);
        step(1, 24'h000005, 2'd0, 0, 0);
        in_instr = 24'h00000A;
        for (int i = 0; i < 5; i++) begin
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp hold", 32'(out_imm), 32'h000005);
            @(posedge clk);
            #1;
        end
        step(1, 24'h00000A, 2'd0, 1, 0);
        chk("bp refill valid", 32'(out_valid), 32'd1);
        chk("bp refill imm", 32'(out_imm), 32'h00000A);

        // Flush between LONG beats
        step(0, 24'h0, 2'd0, 1, 0);
        step(1, 24'h000123, 2'd3, 1, 0);
        flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        step(1, 24'h000999, 2'd0, 1, 1);
        step(1, 24'h000001, 2'd0, 1, 0);
        chk("post-flush imm", 32'(out_imm), 32'h000001);
        chk("post-flush long", 32'(out_long), 32'd0);

        // Asynchronous reset with a held operand, and again mid-LONG
        step(1, 24'h000777, 2'd0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst imm", 32'(out_imm), 32'h000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 24'h000123, 2'd3, 1, 0);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 24'h000080, 2'd0, 1, 0);
        chk("post-rst imm", 32'(out_imm), 32'hFFFF80);
        chk("post-rst long", 32'(out_long), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 24'($urandom), 2'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        step(0, 24'h0, 2'd0, 1, 0);
        step(0, 24'h0, 2'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
